// File: rtl/alu_rf_sequencer.sv
// Multicycle sequencer for the ALU/register-file datapath: accepts one instruction,
// runs it through IDLE -> EXEC -> WB, and reports completion with a one-cycle done pulse.
module alu_rf_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [31:0] ALUOut,
  input  logic [1:0]  Zero,
  output logic [4:0]  Read1,
  output logic [4:0]  Read2,
  output logic [4:0]  WriteReg,
  output logic [1:0]  RegWrite,
  output logic [31:0] WriteData,
  output logic [3:0]  FuncCode,
  output logic [1:0]  ALUOp,
  output logic        done,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        illegal,
  output logic [1:0]  state_dbg
);

  // Handshake: an instruction transfers on the rising edge where instr_valid && instr_ready;
  // instr is sampled only at that edge, and instr_valid is ignored outside IDLE.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, dest;
  logic [15:0] imm;
  logic        is_rtype, is_lui, is_beq, is_illegal;
  logic        writes_reg, write_en;
  logic [31:0] exec_result;

  always_comb begin
    opcode     = ir_q[31:26];
    rs         = ir_q[25:21];
    rt         = ir_q[20:16];
    rd         = ir_q[15:11];
    imm        = ir_q[15:0];
    is_rtype   = (opcode == OP_RTYPE);
    is_lui     = (opcode == OP_LUI);
    is_beq     = (opcode == OP_BEQ);
    is_illegal = !(is_rtype || is_lui || is_beq);
    dest       = is_rtype ? rd : rt;
    writes_reg = is_rtype || is_lui;
    // Register 0 is hardwired; a write aimed at it still completes but never reaches the file.
    write_en   = writes_reg && (dest != 5'd0);
    if (is_lui)          exec_result = {imm, 16'h0000};
    else if (is_illegal) exec_result = 32'h0;
    else                 exec_result = ALUOut;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= 32'h0;
      result_q <= 32'h0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = exec_result;
        // Only bit 0 carries the flag; the upper bit is masked off.
        zero_d   = |(Zero & 2'b01);
        state_d  = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are forced quiet while reset is high, which also kills an in-flight write.
  always_comb begin
    instr_ready  = 1'b0;
    Read1        = 5'd0;
    Read2        = 5'd0;
    FuncCode     = 4'd0;
    ALUOp        = 2'b00;
    WriteReg     = 5'd0;
    RegWrite     = 2'b00;
    WriteData    = 32'h0;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    result       = 32'h0;
    state_dbg    = 2'd0;
    if (!reset) begin
      result    = result_q;
      state_dbg = state_q;
      case (state_q)
        S_IDLE: instr_ready = 1'b1;
        S_EXEC: begin
          Read1 = rs;
          Read2 = rt;
          if (is_rtype) begin
            ALUOp    = 2'b10;
            FuncCode = ir_q[3:0];
          end else if (is_beq) begin
            ALUOp    = 2'b01;
          end
        end
        S_WB: begin
          done         = 1'b1;
          WriteData    = result_q;
          WriteReg     = writes_reg ? dest : 5'd0;
          RegWrite     = write_en ? 2'b01 : 2'b00;
          branch_taken = is_beq && zero_q;
          illegal      = is_illegal;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: a behavioural datapath (register file + ALU) closes the loop,
// a scoreboard model predicts each instruction's completion and a monitor checks every done.
module tb_alu_rf_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] ALUOut;
  logic [1:0]  Zero;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [1:0]  RegWrite;
  logic [31:0] WriteData;
  logic [3:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic        done;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;
  logic [1:0]  state_dbg;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // Expected entry: {illegal, branch, write_en, write_reg[4:0], result[31:0]}
  logic [39:0] exp_q[$];
  logic [31:0] model_rf [32];

  logic [31:0] dp_rf [32];
  logic        poke_en;
  logic [4:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] op_a, op_b;

  alu_rf_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ALUOut(ALUOut), .Zero(Zero), .Read1(Read1),
    .Read2(Read2), .WriteReg(WriteReg), .RegWrite(RegWrite), .WriteData(WriteData),
    .FuncCode(FuncCode), .ALUOp(ALUOp), .done(done), .result(result),
    .branch_taken(branch_taken), .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: combinational read + ALU, write committed on the rising edge.
  always_comb begin
    op_a = dp_rf[Read1];
    op_b = dp_rf[Read2];
    case (ALUOp)
      2'b00: ALUOut = op_a + op_b;
      2'b01: ALUOut = op_a - op_b;
      2'b10: begin
        case (FuncCode)
          4'h0:    ALUOut = op_a + op_b;
          4'h2:    ALUOut = op_a - op_b;
          4'h4:    ALUOut = op_a & op_b;
          4'h5:    ALUOut = op_a | op_b;
          4'hA:    ALUOut = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
          default: ALUOut = 32'h0;
        endcase
      end
      default: ALUOut = 32'h0;
    endcase
    Zero = {1'b0, (ALUOut == 32'h0)};
  end

  always @(posedge clk) begin
    if (poke_en)                dp_rf[poke_addr] <= poke_data;
    else if (RegWrite == 2'b01) dp_rf[WriteReg]  <= WriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference model: architectural effect of one instruction on the register state.
  task automatic model_push(input logic [31:0] w);
    logic [5:0]  op;
    logic [31:0] a, b, d;
    logic [4:0]  wreg;
    logic        we, br, ill;
    op = w[31:26];
    a = model_rf[w[25:21]];
    b = model_rf[w[20:16]];
    d = 32'h0; wreg = 5'd0; we = 1'b0; br = 1'b0; ill = 1'b0;
    if (op == 6'h00) begin
      case (w[5:0])
        6'h20:   d = a + b;
        6'h22:   d = a - b;
        6'h24:   d = a & b;
        6'h25:   d = a | b;
        6'h2A:   d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: d = 32'h0;
      endcase
      we = (w[15:11] != 5'd0);
      wreg = we ? w[15:11] : 5'd0;
    end else if (op == 6'h0F) begin
      d = {w[15:0], 16'h0000};
      we = (w[20:16] != 5'd0);
      wreg = we ? w[20:16] : 5'd0;
    end else if (op == 6'h04) begin
      d = a - b;
      br = (a == b);
    end else begin
      ill = 1'b1;
    end
    exp_q.push_back({ill, br, we, wreg, d});
    if (we) model_rf[wreg] = d;
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    model_rf[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Driver: presents w until accepted; returns just after the accepting edge with the
  // accept cycle in acc. With hold set, instr_valid stays high for the next send.
  task automatic send(input logic [31:0] w, input bit hold, input bit expect_done,
                      output int acc);
    int budget;
    budget = 60;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      failed++; tests++;
      $display("FAIL accept_timeout: got no instr_ready expected ready within 60 cycles");
    end
    if (expect_done) model_push(w);
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) begin
      instr_valid = 1'b0;
      instr = $urandom;
    end
  endtask

  // Monitor: checks each done against the scoreboard; quiet outputs otherwise.
  initial begin : monitor
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!reset && cyc > 1) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("result", result, e[31:0]);
            check("write_data", WriteData, e[31:0]);
            check("reg_write", {30'd0, RegWrite}, {31'd0, e[37]});
            if (e[37]) check("write_reg", {27'd0, WriteReg}, {27'd0, e[36:32]});
            check("branch_taken", {31'd0, branch_taken}, {31'd0, e[38]});
            check("illegal", {31'd0, illegal}, {31'd0, e[39]});
          end
        end else begin
          check("idle_wb_outputs", {RegWrite, branch_taken, illegal, WriteReg, WriteData}, 32'h0);
          check("idle_wb_data", WriteData, 32'h0);
        end
      end
    end
  end

  initial begin : stimulus
    int a0, a1, a2, dummy, budget;
    logic [31:0] w, saved;
    logic [5:0]  functs [5];
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A;
    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0;
    poke_en = 1'b0; poke_addr = 5'd0; poke_data = 32'h0;

    // Register preload under reset, then reset quiet-output checks.
    for (int i = 0; i < 32; i++) poke(i[4:0], (i == 0) ? 32'h0 : $urandom);
    poke(5'd1, 32'd5);
    poke(5'd2, 32'd7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_ready", {31'd0, instr_ready}, 32'd0);
      check("reset_outputs", {Read1, Read2, RegWrite, FuncCode, ALUOp, done, branch_taken,
                              illegal, WriteReg, 3'd0}, 32'h0);
      check("reset_result", result | WriteData, 32'h0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, instr_ready}, 32'd1);
    check("post_reset_result", result, 32'h0);
    check("post_reset_outputs", {Read1, Read2, RegWrite, FuncCode, ALUOp, done, WriteReg, 8'd0},
          32'h0);

    // R-type add $3 = $1 + $2
    send(r_type(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b1, dummy);
    @(negedge clk);
    check("exec_read1", {27'd0, Read1}, 32'd1);
    check("exec_read2", {27'd0, Read2}, 32'd2);
    check("exec_aluop", {30'd0, ALUOp}, 32'd2);
    check("exec_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("wb_done", {31'd0, done}, 32'd1);
    check("wb_regwrite", {30'd0, RegWrite}, 32'd1);
    check("wb_writereg", {27'd0, WriteReg}, 32'd3);
    check("wb_writedata", WriteData, 32'd12);
    @(negedge clk);
    check("rf_r3", dp_rf[3], 32'd12);

    // LUI $4 = 0xABCD0000
    send(i_type(6'h0F, 5'd0, 5'd4, 16'hABCD), 1'b0, 1'b1, dummy);
    repeat (3) @(negedge clk);
    check("lui_result", result, 32'hABCD0000);
    check("rf_r4", dp_rf[4], 32'hABCD0000);

    // BEQ equal then unequal
    poke(5'd1, 32'd9);
    poke(5'd2, 32'd9);
    send(i_type(6'h04, 5'd1, 5'd2, 16'h0010), 1'b0, 1'b1, dummy);
    @(negedge clk); @(negedge clk);
    check("beq_eq_taken", {31'd0, branch_taken}, 32'd1);
    poke(5'd2, 32'd8);
    send(i_type(6'h04, 5'd1, 5'd2, 16'h0010), 1'b0, 1'b1, dummy);
    @(negedge clk); @(negedge clk);
    check("beq_ne_taken", {31'd0, branch_taken}, 32'd0);
    check("beq_ne_regwrite", {30'd0, RegWrite}, 32'd0);

    // Write to $0 and illegal opcode
    send(r_type(5'd1, 5'd2, 5'd0, 6'h20), 1'b0, 1'b1, dummy);
    @(negedge clk); @(negedge clk);
    check("r0_done", {31'd0, done}, 32'd1);
    check("r0_regwrite", {30'd0, RegWrite}, 32'd0);
    send(i_type(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b0, 1'b1, dummy);
    @(negedge clk); @(negedge clk);
    check("illegal_flag", {31'd0, illegal}, 32'd1);
    check("illegal_result", result, 32'h0);

    // Reset during EXEC aborts the instruction.
    poke(5'd9, 32'h1234_5678);
    saved = 32'h1234_5678;
    send(r_type(5'd1, 5'd2, 5'd9, 6'h20), 1'b0, 1'b0, dummy);
    reset = 1'b1;
    @(negedge clk);
    check("abort_regwrite", {30'd0, RegWrite}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    check("abort_r9_kept", dp_rf[9], saved);
    check("abort_model_sync", model_rf[9], saved);

    // Back-to-back with instr_valid held high; each reads the previous write.
    send(r_type(5'd1, 5'd2, 5'd5, 6'h20), 1'b1, 1'b1, a0);
    send(r_type(5'd5, 5'd5, 5'd6, 6'h20), 1'b1, 1'b1, a1);
    send(r_type(5'd6, 5'd1, 5'd7, 6'h22), 1'b0, 1'b1, a2);
    check("b2b_gap1", a1 - a0, 32'd3);
    check("b2b_gap2", a2 - a1, 32'd3);
    repeat (3) @(negedge clk);
    check("b2b_r7", dp_rf[7], 32'd17 + 32'd17 - 32'd9);

    // Randomized mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0, 1: w = r_type(rs, rt, rd, functs[$urandom_range(0, 4)]);
        2: w = i_type(6'h0F, rs, rt, 16'($urandom));
        default: begin
          if ($urandom_range(0, 1) == 1) w = i_type(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt,
                                                   16'($urandom));
          else begin
            op = 6'($urandom_range(0, 63));
            while (op == 6'h00 || op == 6'h04 || op == 6'h0F) op = 6'($urandom_range(0, 63));
            w = i_type(op, rs, rt, 16'($urandom));
          end
        end
      endcase
      send(w, ($urandom_range(0, 2) == 0), 1'b1, dummy);
    end
    instr_valid = 1'b0;

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    check("drain_pending", exp_q.size(), 32'd0);
    for (int i = 1; i < 32; i++) check("final_rf", dp_rf[i], model_rf[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
